// File: rtl/alu_issue_stage_if.sv
// Shared ALU operation encoding, and the ID/EX handshake bundle that carries a
// decoded ALU operation from the issue stage to the EX stage.
//
// alu_op_pkg
//   alu_op_t : 4-bit ALU operation code consumed by the EX-stage ALU.
//
// alu_issue_stage_if (signal names match the original flat ports)
//   out_valid   : decoded entry present                 (master -> slave)
//   out_ready   : EX stage consumes the entry           (slave  -> master)
//   alu_op_ctrl : ALU operation                         (master -> slave)
//   alu_in1/2   : ALU operands                          (master -> slave)
//   rd          : destination register                  (master -> slave)
//   reg_write   : writeback enable                      (master -> slave)
//   is_load / is_store / is_branch : instruction class  (master -> slave)
//   br_funct3   : branch condition for EX compare logic (master -> slave)
//   illegal     : unsupported or malformed encoding     (master -> slave)

package alu_op_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    import alu_op_pkg::*;

    logic            out_valid;
    logic            out_ready;
    alu_op_t         alu_op_ctrl;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic            illegal;

    modport master (
        output out_valid, alu_op_ctrl, alu_in1, alu_in2, rd, reg_write,
               is_load, is_store, is_branch, br_funct3, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, alu_op_ctrl, alu_in1, alu_in2, rd, reg_write,
               is_load, is_store, is_branch, br_funct3, illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes an instruction into an ALU operation plus
// operands and registers the result into the ID/EX boundary through a
// 2-entry (output + skid) buffer, giving full throughput under backpressure.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : synchronous kill of both buffer entries and the input
//   in_valid     : upstream offers an instruction
//   in_ready     : block can accept (registered, NOT skid_valid)
//   instr, pc    : instruction word and its address
//   rs1_data/rs2_data : register-file read data
//   alu          : master side of alu_issue_stage_if towards the EX stage

module alu_issue_stage
    import alu_op_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   instr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    alu_issue_stage_if.master alu
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        alu_op_t         alu_op;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic [2:0]      br_funct3;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            legal;
    entry_t          dec;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    // Shared R/I operation map; alt selects SUB/SRA variants.
    function automatic alu_op_t op_map(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  op_map = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op_map = ALU_SLL;
            3'b010:  op_map = ALU_SLT;
            3'b011:  op_map = ALU_SLTU;
            3'b100:  op_map = ALU_XOR;
            3'b101:  op_map = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op_map = ALU_OR;
            default: op_map = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec       = '0;
        dec.rd    = instr[11:7];
        legal     = 1'b0;
        case (opcode)
            OP_R: begin
                dec.alu_op    = op_map(f3, f7 == F7_ALT);
                dec.in1       = rs1_data;
                dec.in2       = rs2_data;
                dec.reg_write = 1'b1;
                legal = (f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_I: begin
                dec.alu_op    = op_map(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                dec.in1       = rs1_data;
                dec.reg_write = 1'b1;
                case (f3)
                    3'b001: begin
                        dec.in2 = {27'b0, instr[24:20]};
                        legal   = (f7 == F7_ZERO);
                    end
                    3'b101: begin
                        dec.in2 = {27'b0, instr[24:20]};
                        legal   = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    end
                    default: begin
                        dec.in2 = imm_i;
                        legal   = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                dec.alu_op    = ALU_ADD;
                dec.in2       = imm_u;
                dec.reg_write = 1'b1;
                legal         = 1'b1;
            end
            OP_AUIPC: begin
                dec.alu_op    = ALU_ADD;
                dec.in1       = pc;
                dec.in2       = imm_u;
                dec.reg_write = 1'b1;
                legal         = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_op    = ALU_ADD;
                dec.in1       = rs1_data;
                dec.in2       = imm_i;
                dec.is_load   = 1'b1;
                dec.reg_write = 1'b1;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
            end
            OP_STORE: begin
                dec.alu_op   = ALU_ADD;
                dec.in1      = rs1_data;
                dec.in2      = imm_s;
                dec.is_store = 1'b1;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            OP_BRANCH: begin
                dec.in1       = rs1_data;
                dec.in2       = rs2_data;
                dec.is_branch = 1'b1;
                dec.br_funct3 = f3;
                legal         = 1'b1;
                case (f3)
                    3'b000, 3'b001: dec.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec.alu_op = ALU_SLTU;
                    default:        legal      = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Illegal entries still travel the buffer, but carry no side effects.
        if (!legal) begin
            dec         = '0;
            dec.rd      = instr[11:7];
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output + skid buffer
    // ------------------------------------------------------------------
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   accept;
    logic   fire;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign fire     = out_valid_q & alu.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q) begin
            if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end
        end else if (fire) begin
            // accept cannot coincide with a full skid since in_ready is low.
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign alu.out_valid   = out_valid_q;
    assign alu.alu_op_ctrl = out_q.alu_op;
    assign alu.alu_in1     = out_q.in1;
    assign alu.alu_in2     = out_q.in2;
    assign alu.rd          = out_q.rd;
    assign alu.reg_write   = out_q.reg_write;
    assign alu.is_load     = out_q.is_load;
    assign alu.is_store    = out_q.is_store;
    assign alu.is_branch   = out_q.is_branch;
    assign alu.br_funct3   = out_q.br_funct3;
    assign alu.illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a decode vector table streamed with
// out_ready high, then hand-written backpressure, flush and reset sequences.

module tb_alu_issue_stage;
    import alu_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int unsigned tests = 0;
    int unsigned fails = 0;

    alu_issue_stage_if #(.XLEN(32)) alu ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu      (alu.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        alu_op_t     op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic        br;
        logic [2:0]  bf3;
        logic        ill;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input vec_t v);
        chk({v.name, ".valid"},  32'(alu.out_valid),   32'd1);
        chk({v.name, ".op"},     32'(alu.alu_op_ctrl), 32'(v.op));
        chk({v.name, ".in1"},    alu.alu_in1,          v.in1);
        chk({v.name, ".in2"},    alu.alu_in2,          v.in2);
        chk({v.name, ".rd"},     32'(alu.rd),          32'(v.rd));
        chk({v.name, ".rw"},     32'(alu.reg_write),   32'(v.rw));
        chk({v.name, ".ld"},     32'(alu.is_load),     32'(v.ld));
        chk({v.name, ".st"},     32'(alu.is_store),    32'(v.st));
        chk({v.name, ".br"},     32'(alu.is_branch),   32'(v.br));
        chk({v.name, ".bf3"},    32'(alu.br_funct3),   32'(v.bf3));
        chk({v.name, ".ill"},    32'(alu.illegal),     32'(v.ill));
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".valid"}, 32'(alu.out_valid),   32'd0);
        chk({name, ".ready"}, 32'(in_ready),        32'd1);
        chk({name, ".op"},    32'(alu.alu_op_ctrl), 32'(ALU_ADD));
        chk({name, ".in1"},   alu.alu_in1,          32'd0);
        chk({name, ".in2"},   alu.alu_in2,          32'd0);
        chk({name, ".flags"}, {24'd0, alu.rd, alu.reg_write, alu.is_load, alu.is_store},  32'd0);
        chk({name, ".misc"},  {27'd0, alu.is_branch, alu.br_funct3, alu.illegal}, 32'd0);
    endtask

    // addi xN, x0, N : identifies entries in the handshake sequences
    function automatic logic [31:0] addi_n(input logic [4:0] n);
        return {7'd0, n, 5'd0, 3'b000, n, 7'b0010011};
    endfunction

    // Fill output and skid with addi x1 / addi x2 under out_ready=0.
    task automatic fill_two();
        alu.out_ready = 1'b0;
        in_valid = 1'b1; instr = addi_n(5'd1); rs1_data = '0;
        tick();
        instr = addi_n(5'd2);
        tick();
    endtask

    initial begin
        vecs[0]  = '{"add",   32'h002081B3, 0, 5, 7, ALU_ADD, 5, 7, 3, 1, 0, 0, 0, 3'd0, 0};
        vecs[1]  = '{"sub",   32'h402081B3, 0, 5, 7, ALU_SUB, 5, 7, 3, 1, 0, 0, 0, 3'd0, 0};
        vecs[2]  = '{"addi",  32'hFFF00093, 0, 0, 0, ALU_ADD, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 3'd0, 0};
        vecs[3]  = '{"srai",  32'h40335293, 0, 32'h80000000, 0, ALU_SRA, 32'h80000000, 3, 5, 1, 0, 0, 0, 3'd0, 0};
        vecs[4]  = '{"lui",   32'h123450B7, 0, 32'hDEAD, 0, ALU_ADD, 0, 32'h12345000, 1, 1, 0, 0, 0, 3'd0, 0};
        vecs[5]  = '{"auipc", 32'hFFFFF117, 32'h1000, 0, 0, ALU_ADD, 32'h1000, 32'hFFFFF000, 2, 1, 0, 0, 0, 3'd0, 0};
        vecs[6]  = '{"bltu",  32'h0020E063, 0, 10, 20, ALU_SLTU, 10, 20, 0, 0, 0, 0, 1, 3'd6, 0};
        vecs[7]  = '{"mul",   32'h02208133, 0, 5, 7, ALU_ADD, 0, 0, 2, 0, 0, 0, 0, 3'd0, 1};
        vecs[8]  = '{"op7f",  32'h0000007F, 0, 5, 7, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1};
        vecs[9]  = '{"lw",    32'hFFC0A203, 0, 32'h100, 0, ALU_ADD, 32'h100, 32'hFFFFFFFC, 4, 1, 1, 0, 0, 3'd0, 0};
        vecs[10] = '{"sw",    32'h0020A423, 0, 32'h200, 9, ALU_ADD, 32'h200, 8, 8, 0, 0, 1, 0, 3'd0, 0};
        vecs[11] = '{"ldf3",  32'h0000B203, 0, 1, 0, ALU_ADD, 0, 0, 4, 0, 0, 0, 0, 3'd0, 1};
        vecs[12] = '{"addx0", 32'h00100013, 0, 9, 0, ALU_ADD, 9, 1, 0, 0, 0, 0, 0, 3'd0, 0};
        vecs[13] = '{"sllif7", 32'h40009093, 0, 1, 0, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 3'd0, 1};
        vecs[14] = '{"xorf7", 32'h4020C1B3, 0, 1, 2, ALU_ADD, 0, 0, 3, 0, 0, 0, 0, 3'd0, 1};
        vecs[15] = '{"beq",   32'h00208063, 0, 3, 4, ALU_SUB, 3, 4, 0, 0, 0, 0, 1, 3'd0, 0};
        vecs[16] = '{"brf3",  32'h0020A063, 0, 3, 4, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        pc = '0; rs1_data = 32'd5; rs2_data = 32'd7; alu.out_ready = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Streamed decode table, one entry per cycle.
        foreach (vecs[i]) begin
            instr = vecs[i].instr; pc = vecs[i].pc;
            rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
            in_valid = 1'b1;
            tick();
            chk_entry(vecs[i]);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.valid", 32'(alu.out_valid), 32'd0);
        chk("hold.rd", 32'(alu.rd), 32'(vecs[16].rd));
        chk("hold.ill", 32'(alu.illegal), 32'd1);

        // Backpressure: A in output, B in skid, C held, then in-order drain.
        alu.out_ready = 1'b0;
        in_valid = 1'b1; instr = addi_n(5'd1); rs1_data = '0;
        tick();
        chk("bp.a.rd", 32'(alu.rd), 32'd1);
        chk("bp.a.ready", 32'(in_ready), 32'd1);
        instr = addi_n(5'd2);
        tick();
        chk("bp.b.rd", 32'(alu.rd), 32'd1);
        chk("bp.b.ready", 32'(in_ready), 32'd0);
        instr = addi_n(5'd3);
        tick();
        chk("bp.c.rd", 32'(alu.rd), 32'd1);
        chk("bp.c.in2", alu.alu_in2, 32'd1);
        chk("bp.c.ready", 32'(in_ready), 32'd0);
        alu.out_ready = 1'b1;
        tick();
        chk("bp.out_b.rd", 32'(alu.rd), 32'd2);
        chk("bp.out_b.ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp.out_c.rd", 32'(alu.rd), 32'd3);
        chk("bp.out_c.valid", 32'(alu.out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp.empty", 32'(alu.out_valid), 32'd0);

        // Flush with both entries full and a concurrent offer.
        fill_two();
        chk("fl.full.ready", 32'(in_ready), 32'd0);
        instr = addi_n(5'd3); flush = 1'b1;
        tick();
        chk("fl.valid", 32'(alu.out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; alu.out_ready = 1'b1;
        tick();
        chk("fl.after.valid", 32'(alu.out_valid), 32'd0);
        tick();
        chk("fl.after2.valid", 32'(alu.out_valid), 32'd0);

        // Same with reset instead of flush: everything returns to zero.
        fill_two();
        instr = addi_n(5'd3); rst_n = 1'b0;
        tick();
        chk_zero("rst_mid");
        rst_n = 1'b1; in_valid = 1'b0; alu.out_ready = 1'b1;
        tick();
        chk("rst.after.valid", 32'(alu.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
